led_sequencer: RTL
==================

# led_sequencer

Controller that drives the 8-bit LED register through its `data`/`ack` write port. It accepts bytes from the SPI receiver and runs a prescaled pattern engine with four modes: direct, blink, rotate and count. It arbitrates between SPI writes and pattern steps so that exactly one write per cycle reaches the LED register. It sits between the SPI slave and the LED register.

## Interface

- `DIV_W`, default 24: prescaler counter and `div_i` width.

- `clk_i` input 1: system clock, rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `spi_data_i` input 8: byte received over SPI.
- `spi_valid_i` input 1: one-cycle pulse; `spi_data_i` is valid in that cycle.
- `mode_i` input 2: 00 DIRECT, 01 BLINK, 10 ROTATE, 11 COUNT.
- `enable_i` input 1: allows pattern steps; SPI writes ignore it.
- `div_i` input DIV_W: step period minus one, in clock cycles.
- `data_o` output 8: write data to the LED register; registered.
- `ack_o` output 1: one-cycle write strobe to the LED register; registered.
- `step_o` output 1: one-cycle pulse marking a pattern step; registered, aligned with its `ack_o`.

## Operation

- Internal registers:
  - `seed_q` [7:0]: last SPI byte.
  - `pat_q` [7:0]: current pattern.
  - `phase_q`: blink phase.
  - `cnt_q` [DIV_W-1:0]: prescaler.
  - `mode_q` [1:0]: registered `mode_i`.
- FSM state is derived from `mode_q` and `enable_i`:
  - DIRECT: `mode_q == 00`.
  - RUN: pattern mode and `enable_i == 1`.
  - HOLD: pattern mode and `enable_i == 0`.
- SPI write (`spi_valid_i == 1`), any state:
  - `seed_q <= spi_data_i`, `pat_q <= spi_data_i`, `phase_q <= 0`, `cnt_q <= 0`.
  - Emit a write of `spi_data_i`.
- Mode change (`mode_i != mode_q`, without SPI in the same cycle):
  - `mode_q <= mode_i`, `pat_q <= seed_q`, `phase_q <= 0`, `cnt_q <= 0`.
  - Emit a write of `seed_q`.
- Prescaler:
  - Increments only in RUN.
  - Terminal when `cnt_q >= div_i`; the `>=` compare tolerates `div_i` shrinking mid-count.
  - On terminal: `cnt_q <= 0` and one step fires.
  - `div_i == 0` gives one step per cycle.
- Step update rules:
  - BLINK: `phase_q` toggles; write `seed_q` if the new phase is 0, else `8'h00`.
  - ROTATE: `pat_q <= {pat_q[6:0], pat_q[7]}`; write the new value.
  - COUNT: `pat_q <= pat_q + 1` mod 256 (8'hFF wraps to 8'h00); write the new value.
- HOLD: `cnt_q` and `pat_q` are frozen. `data_o` keeps its last value and no `ack_o` is issued.
- Arbitration, highest priority first: SPI write > mode change > pattern step.
  - A step that loses arbitration is dropped, not deferred. Its prescaler restart comes from the winning event.
  - `mode_q` always updates when `mode_i` differs. If SPI wins the same cycle, the mode update happens but only the SPI write is emitted.
- Write port: at most one `ack_o` per cycle. `data_o` changes only together with `ack_o` and holds its value otherwise.

## Timing

- Reset values (async assert, sync-safe deassert):
  - `data_o = 0`, `ack_o = 0`, `step_o = 0`.
  - `seed_q = 0`, `pat_q = 0`, `phase_q = 0`, `cnt_q = 0`, `mode_q = 00`.
- Reset mid-operation aborts immediately. No `ack_o` is issued after reset release until a new event occurs.
- Latency:
  - An event in cycle N produces `ack_o = 1` and the new `data_o` in cycle N+1.
  - The LED register captures the value on the N+1 edge.
- Step period in RUN: `div_i + 1` cycles between consecutive `step_o` pulses.
  - The first step comes `div_i + 1` cycles after an SPI write, mode change, or entry into RUN from HOLD.
- `div_i` is sampled every cycle and is not latched.
- `spi_valid_i` on back-to-back cycles produces back-to-back `ack_o`. Each write carries its own byte.

## Test plan

- Reset/direct:
  - Stimulus: assert `rst_ni = 0` mid-blink, then release; mode 00; SPI byte 8'hA5.
  - Required: all outputs 0 during reset; a single `ack_o` one cycle after `spi_valid_i` with `data_o = 8'hA5`; no further acks.
- Blink:
  - Stimulus: SPI 8'h3C, mode 01, `div_i = 3`, enable 1.
  - Required: write 8'h3C on the mode change, then steps every 4 cycles writing 00, 3C, 00, …
- Rotate:
  - Stimulus: SPI 8'h81, mode 10, `div_i = 0`.
  - Required: `data_o` sequence 81 (mode-change write), 03, 06, 0C, … with one `ack_o` per cycle.
- Count wrap:
  - Stimulus: SPI 8'hFE, mode 11, `div_i = 1`.
  - Required: FE (mode-change write), then FF, 00, 01 with steps every 2 cycles.
- Collision:
  - Stimulus: SPI 8'h55 arrives in the same cycle as a prescaler terminal and a mode change.
  - Required: only the 8'h55 write is emitted; `step_o = 0`; `mode_q` is updated; the next step comes `div_i + 1` cycles later.
- Hold/div shrink:
  - Stimulus: drop `enable_i` to 0 at `cnt_q = 5`.
  - Required: no acks while held, `cnt_q` frozen at 5.
  - Stimulus: re-enable with `div_i` lowered from 10 to 2.
  - Required: a step on the next cycle (`cnt_q >= div_i`), then steps every 3 cycles.

Source files
------------

// File: rtl/led_sequencer.sv
// LED pattern controller: merges SPI byte writes and prescaled pattern steps
// (blink/rotate/count) into a single registered data/ack write port.
module led_sequencer #(
    parameter int DIV_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       spi_data_i,
    input  logic             spi_valid_i,
    input  logic [1:0]       mode_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_i,
    output logic [7:0]       data_o,
    output logic             ack_o,
    output logic             step_o
);

    typedef enum logic [1:0] {
        ST_DIRECT,
        ST_RUN,
        ST_HOLD
    } state_e;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    logic [7:0]       r_seed;
    logic [7:0]       r_pat;
    logic             r_phase;
    logic [DIV_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic [7:0]       r_data;
    logic             r_ack;
    logic             r_step;

    state_e           w_state;
    logic             w_modeChg;
    logic             w_terminal;
    logic [7:0]       w_seedNext;
    logic [7:0]       w_patNext;
    logic             w_phaseNext;
    logic [DIV_W-1:0] w_cntNext;
    logic [1:0]       w_modeNext;
    logic [7:0]       w_dataNext;
    logic             w_ackNext;
    logic             w_stepNext;

    // The operating state is a pure function of the registered mode and enable.
    always_comb begin
        w_state = ST_DIRECT;
        if (r_mode != MODE_DIRECT) begin
            w_state = enable_i ? ST_RUN : ST_HOLD;
        end
    end

    assign w_modeChg  = (mode_i != r_mode);
    assign w_terminal = (w_state == ST_RUN) && (r_cnt >= div_i);

    // Priority: SPI write, then mode change, then a pattern step; losers are dropped.
    always_comb begin
        w_seedNext  = r_seed;
        w_patNext   = r_pat;
        w_phaseNext = r_phase;
        w_cntNext   = r_cnt;
        w_modeNext  = r_mode;
        w_dataNext  = r_data;
        w_ackNext   = 1'b0;
        w_stepNext  = 1'b0;

        if (spi_valid_i) begin
            w_seedNext  = spi_data_i;
            w_patNext   = spi_data_i;
            w_phaseNext = 1'b0;
            w_cntNext   = '0;
            w_modeNext  = mode_i;
            w_dataNext  = spi_data_i;
            w_ackNext   = 1'b1;
        end else if (w_modeChg) begin
            w_modeNext  = mode_i;
            w_patNext   = r_seed;
            w_phaseNext = 1'b0;
            w_cntNext   = '0;
            w_dataNext  = r_seed;
            w_ackNext   = 1'b1;
        end else if (w_state == ST_RUN) begin
            if (w_terminal) begin
                w_cntNext  = '0;
                w_ackNext  = 1'b1;
                w_stepNext = 1'b1;
                case (r_mode)
                    MODE_BLINK: begin
                        w_phaseNext = ~r_phase;
                        w_dataNext  = r_phase ? r_seed : 8'h00;
                    end
                    MODE_ROTATE: begin
                        w_patNext  = {r_pat[6:0], r_pat[7]};
                        w_dataNext = {r_pat[6:0], r_pat[7]};
                    end
                    MODE_COUNT: begin
                        w_patNext  = r_pat + 8'd1;
                        w_dataNext = r_pat + 8'd1;
                    end
                    default: begin
                        w_ackNext  = 1'b0;
                        w_stepNext = 1'b0;
                    end
                endcase
            end else begin
                w_cntNext = r_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_seed  <= 8'h00;
            r_pat   <= 8'h00;
            r_phase <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= MODE_DIRECT;
            r_data  <= 8'h00;
            r_ack   <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            r_seed  <= w_seedNext;
            r_pat   <= w_patNext;
            r_phase <= w_phaseNext;
            r_cnt   <= w_cntNext;
            r_mode  <= w_modeNext;
            r_data  <= w_dataNext;
            r_ack   <= w_ackNext;
            r_step  <= w_stepNext;
        end
    end

    assign data_o = r_data;
    assign ack_o  = r_ack;
    assign step_o = r_step;

endmodule
